// File: rtl/sel_scan_pkg.sv
// Shared types and constants for the select-code scan sequencer.
package sel_scan_pkg;

  localparam int unsigned CODE_W = 3;
  localparam logic [CODE_W-1:0] CODE_LAST = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  // Dwell of zero behaves as a single-cycle slot.
  function automatic logic [15:0] dwell_clamp16(input logic [15:0] d);
    return (d == '0) ? 16'd1 : d;
  endfunction

endpackage

// File: rtl/sel_dwell_timer.sv
// Per-slot dwell timer: latches the slot length on load, counts while running and
// flags the last cycle of the slot.
module sel_dwell_timer #(
  parameter int unsigned DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               run,
  input  logic [DWELL_W-1:0] dwell,
  output logic               expire
);

  logic [DWELL_W-1:0] dlim;
  logic [DWELL_W-1:0] cnt;

  // Latch the slot length at slot entry (0 acts as 1) and count cycles spent in the slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      dlim <= DWELL_W'(1);
      cnt  <= '0;
    end else if (load) begin
      dlim <= (dwell == '0) ? DWELL_W'(1) : dwell;
      cnt  <= '0;
    end else if (run) begin
      cnt <= cnt + DWELL_W'(1);
    end
  end

  // Asserted during the final cycle of the current slot.
  assign expire = run && (cnt == dlim - DWELL_W'(1));

endmodule

// File: rtl/sel_scan_sequencer.sv
// Select-code scan sequencer: steps {sel_en,sel_a,sel_b} through 0..7 with a
// programmable dwell per code, single-pass or continuous, with a forced-code hold.
module sel_scan_sequencer
  import sel_scan_pkg::*;
#(
  parameter int unsigned DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               force_valid,
  input  logic [CODE_W-1:0]  force_code,
  output logic               force_ready,
  output logic               sel_en,
  output logic               sel_a,
  output logic               sel_b,
  output logic               code_valid,
  output logic               pass_done,
  output logic               busy
);

  state_e             state;
  state_e             ret_state;
  logic [CODE_W-1:0]  code;
  logic [CODE_W-1:0]  saved_code;

  logic accept;
  logic start_go;
  logic step;
  logic hold_end;
  logic wrap;
  logic finish;
  logic timer_load;
  logic timer_run;
  logic expire;

  // Decode this cycle's single winning event; stop outranks a force request even
  // though force_ready is high, so the requester simply keeps asserting.
  always_comb begin
    force_ready = (state != HOLD);
    accept      = force_valid && force_ready && !stop;
    start_go    = start && !stop && !accept && (state == IDLE);
    step        = (state == RUN) && expire && !stop && !accept;
    hold_end    = (state == HOLD) && expire && !stop;
    wrap        = step && (code == CODE_LAST);
    finish      = wrap && mode;
    timer_load  = accept || start_go || (step && !finish) || (hold_end && (ret_state == RUN));
    timer_run   = (state != IDLE);
  end

  sel_dwell_timer #(
    .DWELL_W(DWELL_W)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (timer_load),
    .run   (timer_run),
    .dwell (dwell),
    .expire(expire)
  );

  // Sequencer FSM with code register and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ret_state  <= IDLE;
      code       <= '0;
      saved_code <= '0;
      code_valid <= 1'b0;
      pass_done  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      pass_done <= wrap;
      if (stop) begin
        state      <= IDLE;
        code_valid <= 1'b0;
        busy       <= 1'b0;
      end else if (accept) begin
        saved_code <= code;
        ret_state  <= state;
        code       <= force_code;
        state      <= HOLD;
        code_valid <= 1'b1;
        busy       <= 1'b1;
      end else if (start_go) begin
        code       <= '0;
        state      <= RUN;
        code_valid <= 1'b1;
        busy       <= 1'b1;
      end else if (step) begin
        if (finish) begin
          // Single pass ends on the last code, which stays on the outputs.
          state      <= IDLE;
          code_valid <= 1'b0;
          busy       <= 1'b0;
        end else begin
          code <= code + CODE_W'(1);
        end
      end else if (hold_end) begin
        code       <= saved_code;
        state      <= ret_state;
        code_valid <= (ret_state == RUN);
        busy       <= (ret_state == RUN);
      end
    end
  end

  assign {sel_en, sel_a, sel_b} = code;

endmodule

// File: tb/tb_sel_scan_sequencer.sv
// Self-checking bench for sel_scan_sequencer: directed scenarios plus random stimulus,
// every cycle compared against a slot-countdown reference model.
module tb_sel_scan_sequencer;

  localparam int unsigned DWELL_W = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               stop;
  logic               mode;
  logic [DWELL_W-1:0] dwell;
  logic               force_valid;
  logic [2:0]         force_code;
  logic               force_ready;
  logic               sel_en;
  logic               sel_a;
  logic               sel_b;
  logic               code_valid;
  logic               pass_done;
  logic               busy;

  int checks = 0;
  int errors = 0;

  // Reference model: state 0=idle 1=run 2=hold, rem = cycles left showing current code.
  int m_st;
  int m_code;
  int m_saved;
  int m_ret;
  int m_rem;
  int m_pd;

  sel_scan_sequencer #(
    .DWELL_W(DWELL_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .mode       (mode),
    .dwell      (dwell),
    .force_valid(force_valid),
    .force_code (force_code),
    .force_ready(force_ready),
    .sel_en     (sel_en),
    .sel_a      (sel_a),
    .sel_b      (sel_b),
    .code_valid (code_valid),
    .pass_done  (pass_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int slot_len(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    if (rst) begin
      m_st = 0; m_code = 0; m_saved = 0; m_ret = 0; m_rem = 0; m_pd = 0;
    end else begin
      m_pd = 0;
      if (stop) begin
        m_st = 0;
      end else if (force_valid && m_st != 2) begin
        m_saved = m_code;
        m_ret   = m_st;
        m_code  = int'(force_code);
        m_st    = 2;
        m_rem   = slot_len(int'(dwell));
      end else if (start && m_st == 0) begin
        m_st   = 1;
        m_code = 0;
        m_rem  = slot_len(int'(dwell));
      end else if (m_st != 0) begin
        m_rem--;
        if (m_rem == 0) begin
          if (m_st == 1) begin
            if (m_code == 7) begin
              m_pd = 1;
              if (mode) m_st = 0;
              else begin
                m_code = 0;
                m_rem  = slot_len(int'(dwell));
              end
            end else begin
              m_code = m_code + 1;
              m_rem  = slot_len(int'(dwell));
            end
          end else begin
            m_code = m_saved;
            m_st   = m_ret;
            if (m_ret == 1) m_rem = slot_len(int'(dwell));
          end
        end
      end
    end
  endtask

  // One clock: step the model, then compare all outputs on the falling edge.
  task automatic cyc();
    model_step();
    @(negedge clk);
    check_eq("code", {29'd0, sel_en, sel_a, sel_b}, m_code);
    check_eq("code_valid", code_valid, m_st != 0);
    check_eq("busy", busy, m_st != 0);
    check_eq("pass_done", pass_done, m_pd);
    check_eq("force_ready", force_ready, m_st != 2);
  endtask

  task automatic idle_inputs();
    rst = 0; start = 0; stop = 0; force_valid = 0; force_code = 3'd0;
  endtask

  int pd_count;
  int pd_at;

  initial begin
    mode = 0; dwell = '0;
    idle_inputs();

    // Reset held two cycles with start asserted.
    rst = 1; start = 1;
    cyc(); cyc();
    check_eq("t1_code", {29'd0, sel_en, sel_a, sel_b}, 0);
    check_eq("t1_busy", busy, 0);
    check_eq("t1_pass_done", pass_done, 0);
    idle_inputs();
    cyc();

    // Continuous scan, dwell 3.
    dwell = 3; mode = 0; start = 1;
    cyc();
    start = 0;
    pd_count = 0; pd_at = -1;
    for (int i = 1; i <= 30; i++) begin
      cyc();
      if (pass_done === 1'b1) begin
        pd_count++;
        pd_at = i;
      end
    end
    check_eq("t2_pd_count", pd_count, 1);
    check_eq("t2_pd_cycle", pd_at, 24);
    check_eq("t2_still_busy", busy, 1);
    stop = 1; cyc(); stop = 0;

    // Single pass, dwell 0.
    dwell = 0; mode = 1; start = 1;
    cyc();
    start = 0;
    for (int i = 1; i <= 8; i++) cyc();
    check_eq("t3_end_busy", busy, 0);
    check_eq("t3_end_code", {29'd0, sel_en, sel_a, sel_b}, 7);
    check_eq("t3_end_pd", pass_done, 1);
    cyc();
    check_eq("t3_pd_clear", pass_done, 0);

    // Force during RUN at code 4, two cycles into the slot.
    dwell = 5; mode = 0; start = 1;
    cyc();
    start = 0;
    for (int i = 1; i <= 22; i++) cyc();
    check_eq("t4_pre_code", {29'd0, sel_en, sel_a, sel_b}, 4);
    force_valid = 1; force_code = 3'd6;
    cyc();
    force_valid = 0;
    check_eq("t4_hold_code", {29'd0, sel_en, sel_a, sel_b}, 6);
    check_eq("t4_hold_ready", force_ready, 0);
    for (int j = 1; j <= 10; j++) begin
      cyc();
      if (j == 4) check_eq("t4_hold_last", {29'd0, sel_en, sel_a, sel_b}, 6);
      if (j == 5) check_eq("t4_restore", {29'd0, sel_en, sel_a, sel_b}, 4);
      if (j == 9) check_eq("t4_restore_last", {29'd0, sel_en, sel_a, sel_b}, 4);
      if (j == 10) check_eq("t4_next", {29'd0, sel_en, sel_a, sel_b}, 5);
    end

    // Stop and force together during RUN.
    stop = 1; force_valid = 1; force_code = 3'd2;
    cyc();
    idle_inputs();
    check_eq("t5_busy", busy, 0);
    check_eq("t5_ready", force_ready, 1);
    check_eq("t5_not_forced", {29'd0, sel_en, sel_a, sel_b}, 5);
    cyc();

    // Mid-slot dwell change, then reset during HOLD.
    dwell = 3; start = 1;
    cyc();
    start = 0;
    cyc();
    dwell = 7;
    for (int i = 0; i < 12; i++) cyc();
    force_valid = 1; force_code = 3'd3;
    cyc();
    force_valid = 0;
    cyc();
    rst = 1;
    cyc();
    check_eq("t6_code", {29'd0, sel_en, sel_a, sel_b}, 0);
    check_eq("t6_busy", busy, 0);
    check_eq("t6_pd", pass_done, 0);
    idle_inputs();
    cyc();

    // Random stimulus.
    for (int i = 0; i < 4000; i++) begin
      rst         = ($urandom_range(0, 199) == 0);
      start       = ($urandom_range(0, 9) == 0);
      stop        = ($urandom_range(0, 39) == 0);
      force_valid = ($urandom_range(0, 11) == 0);
      force_code  = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 19) == 0) mode = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) dwell = DWELL_W'($urandom_range(0, 4));
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
